// File: rtl/program_loader.sv
// Byte-stream program loader: count, HI/LO instruction pairs, checksum; one write per LO byte, one cycle later.
// Never back-pressures while loading; in_ready drops only once the load has finished (DONE or ERR).
module program_loader (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_we,
  output logic [7:0] prog_addr,
  output logic [9:0] prog_wdata,
  output logic       cpu_run,
  output logic       load_done,
  output logic       load_error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] addr_cnt;
  logic [8:0] remaining;
  logic [7:0] sum;
  logic [1:0] opcode;
  logic       accept;

  // in_ready comes straight from the state register so it never depends on in_valid.
  assign in_ready = (state == S_IDLE) || (state == S_HI) ||
                    (state == S_LO)   || (state == S_CSUM);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_cnt   <= 8'd0;
      remaining  <= 9'd0;
      sum        <= 8'd0;
      opcode     <= 2'd0;
      prog_we    <= 1'b0;
      prog_addr  <= 8'd0;
      prog_wdata <= 10'd0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // A count of zero encodes a full 256-instruction image.
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            sum       <= in_data;
            state     <= S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            if (in_data[7:2] != 6'd0) begin
              state      <= S_ERR;
              load_error <= 1'b1;
              cpu_run    <= 1'b0;
            end else begin
              opcode <= in_data[1:0];
              sum    <= sum + in_data;
              state  <= S_LO;
            end
          end
        end
        S_LO: begin
          if (accept) begin
            prog_we    <= 1'b1;
            prog_wdata <= {opcode, in_data};
            prog_addr  <= addr_cnt;
            // Wraps 255 -> 0 on a full-depth load; no write follows the wrap.
            addr_cnt   <= addr_cnt + 8'd1;
            remaining  <= remaining - 9'd1;
            sum        <= sum + in_data;
            state      <= (remaining == 9'd1) ? S_CSUM : S_HI;
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == sum) begin
              state     <= S_DONE;
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state      <= S_ERR;
              load_error <= 1'b1;
              cpu_run    <= 1'b0;
            end
          end
        end
        S_DONE: state <= S_DONE;
        S_ERR:  state <= S_ERR;
        default: begin
          state      <= S_ERR;
          load_error <= 1'b1;
          cpu_run    <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_done_err_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(load_done && load_error));
  a_we_after_lo: assert property (@(posedge clk) disable iff (!reset_n)
    prog_we |-> (state == S_HI || state == S_CSUM));
  a_run_only_done: assert property (@(posedge clk) disable iff (!reset_n)
    cpu_run |-> (state == S_DONE));
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader: expected writes queued by stimulus, checked by a monitor.
module tb_program_loader;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [9:0] prog_wdata;
  logic       cpu_run;
  logic       load_done;
  logic       load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [17:0] exp_q[$];

  program_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_wdata(prog_wdata),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && prog_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {14'd0, prog_addr, prog_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("write", {14'd0, prog_addr, prog_wdata}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [9:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    {31'd0, prog_we},    32'd0);
    check({tag, "_addr"},  {24'd0, prog_addr},  32'd0);
    check({tag, "_wdata"}, {22'd0, prog_wdata}, 32'd0);
    check({tag, "_run"},   {31'd0, cpu_run},    32'd0);
    check({tag, "_done"},  {31'd0, load_done},  32'd0);
    check({tag, "_err"},   {31'd0, load_error}, 32'd0);
  endtask

  task automatic do_reset();
    idle(2);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic drain_check(input string tag);
    idle(3);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  logic [7:0] five_prog[11];
  logic [7:0] sum;
  logic [7:0] lo;
  int w0;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    five_prog = '{8'h05, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33,
                  8'h00, 8'h44, 8'h01, 8'h55};
    #2;
    check_all_zero("por");
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Nominal two-instruction load
    exp_write(8'd0, 10'h005);
    exp_write(8'd1, 10'h380);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h03); send_byte(8'h80);
    check("nom_not_done_early", {31'd0, load_done}, 32'd0);
    send_byte(8'h8A);
    check("nom_done", {31'd0, load_done}, 32'd1);
    check("nom_run",  {31'd0, cpu_run},   32'd1);
    check("nom_err",  {31'd0, load_error}, 32'd0);
    check("nom_rdy",  {31'd0, in_ready},  32'd0);
    send_byte(8'h01); send_byte(8'h02);
    check("nom_sticky", {31'd0, load_done}, 32'd1);
    drain_check("nom");

    // Bad checksum
    do_reset();
    exp_write(8'd0, 10'h005);
    exp_write(8'd1, 10'h380);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h03); send_byte(8'h80); send_byte(8'h8B);
    check("csum_err",  {31'd0, load_error}, 32'd1);
    check("csum_run",  {31'd0, cpu_run},    32'd0);
    check("csum_done", {31'd0, load_done},  32'd0);
    check("csum_rdy",  {31'd0, in_ready},   32'd0);
    send_byte(8'h00); send_byte(8'h07);
    drain_check("csum");

    // Format error on the HI byte
    do_reset();
    w0 = n_writes;
    send_byte(8'h01); send_byte(8'h04);
    check("fmt_err", {31'd0, load_error}, 32'd1);
    check("fmt_rdy", {31'd0, in_ready},   32'd0);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h06);
    check("fmt_sticky", {31'd0, load_error}, 32'd1);
    check("fmt_run",    {31'd0, cpu_run},    32'd0);
    drain_check("fmt");
    check("fmt_no_write", n_writes - w0, 32'd0);

    // Full depth: 256 instructions, checksum computed here
    do_reset();
    w0  = n_writes;
    sum = 8'h00;
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      lo = 8'(i) ^ 8'h5A;
      exp_write(8'(i), {2'(i), lo});
      send_byte({6'd0, 2'(i)});
      send_byte(lo);
      sum = sum + {6'd0, 2'(i)} + lo;
    end
    check("full_not_done", {31'd0, load_done}, 32'd0);
    send_byte(sum);
    check("full_done", {31'd0, load_done}, 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    drain_check("full");
    check("full_write_count", n_writes - w0, 32'd256);

    // Five-instruction load with random idle gaps; checksum 0x0B
    do_reset();
    exp_write(8'd0, 10'h111); exp_write(8'd1, 10'h222); exp_write(8'd2, 10'h333);
    exp_write(8'd3, 10'h044); exp_write(8'd4, 10'h155);
    for (int i = 0; i < 11; i++) begin
      send_byte(five_prog[i]);
      idle($urandom_range(0, 3));
    end
    check("gap_not_done", {31'd0, load_done}, 32'd0);
    send_byte(8'h0B);
    check("gap_done", {31'd0, load_done}, 32'd1);
    drain_check("gap");

    // Reset after the third LO byte, while its write strobe is pending
    do_reset();
    exp_write(8'd0, 10'h111); exp_write(8'd1, 10'h222);
    for (int i = 0; i < 7; i++) send_byte(five_prog[i]);
    check("mid_we_pending", {31'd0, prog_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("mid_queue_empty", exp_q.size(), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    exp_write(8'd0, 10'h111); exp_write(8'd1, 10'h222); exp_write(8'd2, 10'h333);
    exp_write(8'd3, 10'h044); exp_write(8'd4, 10'h155);
    for (int i = 0; i < 11; i++) send_byte(five_prog[i]);
    send_byte(8'h0B);
    check("reload_done", {31'd0, load_done}, 32'd1);
    check("reload_run",  {31'd0, cpu_run},   32'd1);
    drain_check("reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
